map_bus_mux: RTL and testbench
==============================

MAP_BUS_MUX -- requirements
Module: map_bus_mux

Interface
REQ-001 SHALL have parameter NUM_MAP, default 6: number of special mapper channels (1..15); channel 0 is the default LoROM/HiROM mapper, so there are NUM_MAP+1 channels in total.
REQ-002 SHALL have parameter ROM_AW, default 24: ROM address width per channel.
REQ-003 SHALL have parameter RAM_AW, default 20: BSRAM address width per channel.
REQ-004 SHALL have parameter SETTLE_CYC, default 4: number of stable map_active cycles required before a selection takes effect.
REQ-005 SHALL have parameter TURBO_BLK, default 6'b001010: mask of channel-1..NUM_MAP bits that forbid CPU turbo.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high. Ports: mclk input 1 (sole clock); rst input 1 (synchronous, active-high).
REQ-007 map_active  in  NUM_MAP  per-special-mapper active flags.
REQ-008 ch_do, ch_irq_n, ch_rom_addr, ch_rom_d, ch_rom_ce_n, ch_rom_oe_n, ch_rom_we_n, ch_rom_word, ch_bsram_addr, ch_bsram_d, ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n  in  (NUM_MAP+1) x field width, flattened with channel 0 in the LSBs; channel bundle.
REQ-009 di, irq_n, rom_addr, rom_d(16), rom_ce_n, rom_oe_n, rom_we_n, rom_word, bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n  out; registered selected bundle.
REQ-010 sel  out  4  current channel index; sel_valid  out  1  bundle is live.
REQ-011 turbo_allow  out  1; map_err  out  1  sticky illegal-map flag; err_cnt  out  8.

Function
REQ-012 Decode SHALL map a one-hot map_active bit k to channel k+1, and all-zero to channel 0; multi-hot SHALL map to channel 0 and set map_err.
REQ-013 States SHALL be SETTLE, ACTIVE, DRAIN.
REQ-014 SETTLE: a counter SHALL increment while map_active equals its previous-cycle value and clear on any change; when count reaches SETTLE_CYC-1, sel SHALL load the decoded index and the state SHALL go to ACTIVE.
REQ-015 ACTIVE: sel_valid=1; every output bundle field SHALL be the selected channel's inputs registered, so each output has 1 mclk of latency.
REQ-016 ACTIVE: a change of map_active SHALL cause a transition to DRAIN; sel SHALL remain unchanged.
REQ-017 DRAIN: outputs SHALL continue passing the old channel until the old channel's rom_ce_n and bsram_ce_n are both 1 in the same cycle, then the state SHALL go to SETTLE.
REQ-018 SETTLE, idle bundle: di=8'hFF, irq_n=1, all ce_n/oe_n/we_n=1, rom_word=0, addresses and data=0, sel_valid=0.
REQ-019 rom_d SHALL be the channel's rom_d zero-extended to 16 bits; channel rom_addr narrower than ROM_AW SHALL be zero-extended.
REQ-020 turbo_allow SHALL equal ~|(map_active & TURBO_BLK), registered, and SHALL be valid in every state.
REQ-021 map_err SHALL be set on any cycle in which map_active is multi-hot and SHALL be cleared only by rst.
REQ-022 If a map_active change and the drain-complete condition occur in the same cycle in DRAIN, the state SHALL go to SETTLE and the settle counter SHALL be cleared.

Reset
REQ-023 While rst=1: state=SETTLE, counter=0, sel=0, idle bundle, turbo_allow=1, map_err=0, err_cnt=0.
REQ-024 Asserting rst in any state, including DRAIN, SHALL apply REQ-023 at the next mclk edge with no drain.

Configuration
REQ-025 With MAP_BUS_MUX_ERRCNT_EN defined, err_cnt SHALL count the rising edges of the multi-hot condition and saturate at 8'hFF.
REQ-026 With MAP_BUS_MUX_ERRCNT_EN undefined, err_cnt SHALL be constant 0 and no counter logic SHALL be present; map_err is unaffected.

Structure
REQ-027 Shared package map_bus_pkg SHALL hold the state enum, the IDLE_DI constant 8'hFF, and the channel index width constant.
REQ-028 Sub-module map_sel_decode SHALL perform the one-hot to index conversion plus the multi-hot flag; it is purely combinational.

Verification
REQ-029 Reset, then map_active=0 held for 4 cycles -> sel=0, sel_valid=1 on cycle 5; ch0 rom_addr 24'h123456 appears on rom_addr 1 cycle later.
REQ-030 map_active=6'b000100 stable -> sel=3; change to 6'b001000 while ch3 rom_ce_n=0 for 3 cycles -> old channel output continues 3 cycles, then idle bundle, then sel=4 after 4 stable cycles.
REQ-031 map_active=6'b000011 -> sel=0, map_err=1, err_cnt=1 (macro on) or 0 (macro off); toggling to 6'b000001 and back to 6'b000011 -> err_cnt=2.
REQ-032 map_active=6'b001000 -> turbo_allow=0; map_active=6'b000100 -> turbo_allow=1.
REQ-033 rst asserted mid-DRAIN -> next cycle idle bundle, sel=0, map_err=0.
REQ-034 map_active toggles every 2 cycles during SETTLE -> sel_valid stays 0 throughout.

Source files
------------

// File: rtl/map_bus_pkg.sv
// +----------------------------------------------------------------------+
// | map_bus_pkg                                                          |
// | Shared state encoding and constants for the mapper bus multiplexer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package map_bus_pkg;

    localparam int         CH_IDX_W  = 4;
    localparam int         CH_ROM_DW = 8;
    localparam logic [7:0] IDLE_DI   = 8'hFF;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } map_state_e;

endpackage

`default_nettype wire

// File: rtl/map_sel_decode.sv
// +----------------------------------------------------------------------+
// | map_sel_decode                                                       |
// | One-hot mapper flags to channel index; multi-hot falls back to 0.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module map_sel_decode
    import map_bus_pkg::*;
#(
    parameter int NUM_MAP = 6
) (
    input  logic [NUM_MAP-1:0]  map_active,
    output logic [CH_IDX_W-1:0] idx,
    output logic                multi
);

    always_comb begin
        multi = |(map_active & (map_active - NUM_MAP'(1)));
        idx   = '0;
        for (int k = 0; k < NUM_MAP; k++) begin
            if (map_active[k]) begin
                idx = CH_IDX_W'(k + 1);
            end
        end
        if (multi) begin
            idx = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/map_bus_mux.sv
// +----------------------------------------------------------------------+
// | map_bus_mux                                                          |
// | Selects one mapper channel bundle onto the cartridge bus, with a     |
// | settle/drain handshake on mapper changes. Optional error counter     |
// | enabled by MAP_BUS_MUX_ERRCNT_EN.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module map_bus_mux
    import map_bus_pkg::*;
#(
    parameter int                 NUM_MAP    = 6,
    parameter int                 ROM_AW     = 24,
    parameter int                 RAM_AW     = 20,
    parameter int                 SETTLE_CYC = 4,
    parameter logic [NUM_MAP-1:0] TURBO_BLK  = NUM_MAP'(6'b001010)
) (
    input  logic                              mclk,
    input  logic                              rst,
    input  logic [NUM_MAP-1:0]                map_active,
    input  logic [(NUM_MAP+1)*8-1:0]          ch_do,
    input  logic [NUM_MAP:0]                  ch_irq_n,
    input  logic [(NUM_MAP+1)*ROM_AW-1:0]     ch_rom_addr,
    input  logic [(NUM_MAP+1)*CH_ROM_DW-1:0]  ch_rom_d,
    input  logic [NUM_MAP:0]                  ch_rom_ce_n,
    input  logic [NUM_MAP:0]                  ch_rom_oe_n,
    input  logic [NUM_MAP:0]                  ch_rom_we_n,
    input  logic [NUM_MAP:0]                  ch_rom_word,
    input  logic [(NUM_MAP+1)*RAM_AW-1:0]     ch_bsram_addr,
    input  logic [(NUM_MAP+1)*8-1:0]          ch_bsram_d,
    input  logic [NUM_MAP:0]                  ch_bsram_ce_n,
    input  logic [NUM_MAP:0]                  ch_bsram_oe_n,
    input  logic [NUM_MAP:0]                  ch_bsram_we_n,
    output logic [7:0]                        di,
    output logic                              irq_n,
    output logic [ROM_AW-1:0]                 rom_addr,
    output logic [15:0]                       rom_d,
    output logic                              rom_ce_n,
    output logic                              rom_oe_n,
    output logic                              rom_we_n,
    output logic                              rom_word,
    output logic [RAM_AW-1:0]                 bsram_addr,
    output logic [7:0]                        bsram_d,
    output logic                              bsram_ce_n,
    output logic                              bsram_oe_n,
    output logic                              bsram_we_n,
    output logic [CH_IDX_W-1:0]               sel,
    output logic                              sel_valid,
    output logic                              turbo_allow,
    output logic                              map_err,
    output logic [7:0]                        err_cnt
);

    localparam int BUN_W = 8 + 1 + ROM_AW + 16 + 4 + RAM_AW + 8 + 3;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [BUN_W-1:0] IDLE_BUN = {IDLE_DI, 1'b1, {ROM_AW{1'b0}}, 16'h0000,
                                             3'b111, 1'b0, {RAM_AW{1'b0}}, 8'h00, 3'b111};

    map_state_e            r_state, w_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [CH_IDX_W-1:0]   r_sel, w_sel_next;
    logic [NUM_MAP-1:0]    r_prev;
    logic [BUN_W-1:0]      r_bundle;
    logic                  r_turbo;
    logic                  r_map_err;

    logic [CH_IDX_W-1:0]   w_dec_idx;
    logic                  w_multi;
    logic                  w_changed;
    logic                  w_old_idle;
    logic                  w_load;
    logic [BUN_W-1:0]      w_sel_bundle;

    logic [7:0]            w_do;
    logic                  w_irq_n;
    logic [ROM_AW-1:0]     w_rom_addr;
    logic [CH_ROM_DW-1:0]  w_rom_d;
    logic                  w_rom_ce_n, w_rom_oe_n, w_rom_we_n, w_rom_word;
    logic [RAM_AW-1:0]     w_bsram_addr;
    logic [7:0]            w_bsram_d;
    logic                  w_bsram_ce_n, w_bsram_oe_n, w_bsram_we_n;

    map_sel_decode #(
        .NUM_MAP    (NUM_MAP)
    ) u_decode (
        .map_active (map_active),
        .idx        (w_dec_idx),
        .multi      (w_multi)
    );

    assign w_changed = (map_active != r_prev);

    // Channel fields of the currently held selection.
    always_comb begin
        w_do         = IDLE_DI;
        w_irq_n      = 1'b1;
        w_rom_addr   = '0;
        w_rom_d      = '0;
        w_rom_ce_n   = 1'b1;
        w_rom_oe_n   = 1'b1;
        w_rom_we_n   = 1'b1;
        w_rom_word   = 1'b0;
        w_bsram_addr = '0;
        w_bsram_d    = '0;
        w_bsram_ce_n = 1'b1;
        w_bsram_oe_n = 1'b1;
        w_bsram_we_n = 1'b1;
        for (int c = 0; c <= NUM_MAP; c++) begin
            if (r_sel == CH_IDX_W'(c)) begin
                w_do         = ch_do[c*8 +: 8];
                w_irq_n      = ch_irq_n[c];
                w_rom_addr   = ch_rom_addr[c*ROM_AW +: ROM_AW];
                w_rom_d      = ch_rom_d[c*CH_ROM_DW +: CH_ROM_DW];
                w_rom_ce_n   = ch_rom_ce_n[c];
                w_rom_oe_n   = ch_rom_oe_n[c];
                w_rom_we_n   = ch_rom_we_n[c];
                w_rom_word   = ch_rom_word[c];
                w_bsram_addr = ch_bsram_addr[c*RAM_AW +: RAM_AW];
                w_bsram_d    = ch_bsram_d[c*8 +: 8];
                w_bsram_ce_n = ch_bsram_ce_n[c];
                w_bsram_oe_n = ch_bsram_oe_n[c];
                w_bsram_we_n = ch_bsram_we_n[c];
            end
        end
    end

    assign w_old_idle   = w_rom_ce_n & w_bsram_ce_n;
    assign w_sel_bundle = {w_do, w_irq_n, w_rom_addr, {{(16-CH_ROM_DW){1'b0}}, w_rom_d},
                           w_rom_ce_n, w_rom_oe_n, w_rom_we_n, w_rom_word,
                           w_bsram_addr, w_bsram_d, w_bsram_ce_n, w_bsram_oe_n, w_bsram_we_n};

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_sel_next = r_sel;
        case (r_state)
            ST_SETTLE: begin
                if (w_changed) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_sel_next = w_dec_idx;
                    w_next     = ST_ACTIVE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (w_changed) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Drain completion wins over a simultaneous map change.
                if (w_old_idle) begin
                    w_next     = ST_SETTLE;
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_next     = ST_SETTLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // Bus is driven only while the selection stays live across this edge.
    assign w_load = (r_state != ST_SETTLE) && (w_next != ST_SETTLE);

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state   <= ST_SETTLE;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_prev    <= '0;
            r_bundle  <= IDLE_BUN;
            r_turbo   <= 1'b1;
            r_map_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_sel     <= w_sel_next;
            r_prev    <= map_active;
            r_bundle  <= w_load ? w_sel_bundle : IDLE_BUN;
            r_turbo   <= ~|(map_active & TURBO_BLK);
            if (w_multi) begin
                r_map_err <= 1'b1;
            end
        end
    end

    assign {di, irq_n, rom_addr, rom_d, rom_ce_n, rom_oe_n, rom_we_n, rom_word,
            bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n} = r_bundle;

    assign sel         = r_sel;
    assign sel_valid   = (r_state != ST_SETTLE);
    assign turbo_allow = r_turbo;
    assign map_err     = r_map_err;

`ifdef MAP_BUS_MUX_ERRCNT_EN
    logic       r_multi_d;
    logic [7:0] r_err_cnt;

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_multi_d <= 1'b0;
            r_err_cnt <= 8'h00;
        end else begin
            r_multi_d <= w_multi;
            if (w_multi && !r_multi_d && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_map_bus_mux.sv
// +----------------------------------------------------------------------+
// | tb_map_bus_mux                                                       |
// | Directed vector bench for map_bus_mux.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_map_bus_mux;

    localparam int NUM_MAP = 6;
    localparam int NCH     = NUM_MAP + 1;
`ifdef MAP_BUS_MUX_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic               mclk = 1'b0;
    logic               rst;
    logic [NUM_MAP-1:0] map_active;
    logic [NCH*8-1:0]   ch_do, ch_rom_d, ch_bsram_d;
    logic [NCH-1:0]     ch_irq_n, ch_rom_ce_n, ch_rom_oe_n, ch_rom_we_n, ch_rom_word;
    logic [NCH-1:0]     ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;
    logic [NCH*24-1:0]  ch_rom_addr;
    logic [NCH*20-1:0]  ch_bsram_addr;
    logic [7:0]         di, bsram_d, err_cnt;
    logic               irq_n, rom_ce_n, rom_oe_n, rom_we_n, rom_word;
    logic               bsram_ce_n, bsram_oe_n, bsram_we_n;
    logic [23:0]        rom_addr;
    logic [15:0]        rom_d;
    logic [19:0]        bsram_addr;
    logic [3:0]         sel;
    logic               sel_valid, turbo_allow, map_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 mclk = ~mclk;

    map_bus_mux u_dut (
        .mclk(mclk), .rst(rst), .map_active(map_active),
        .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr), .ch_rom_d(ch_rom_d),
        .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_we_n(ch_rom_we_n),
        .ch_rom_word(ch_rom_word), .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
        .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
        .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_d(rom_d), .rom_ce_n(rom_ce_n),
        .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n), .rom_word(rom_word), .bsram_addr(bsram_addr),
        .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
        .sel(sel), .sel_valid(sel_valid), .turbo_allow(turbo_allow), .map_err(map_err),
        .err_cnt(err_cnt)
    );

    typedef struct {
        logic [5:0] ma;
        logic       ce3;
        int         src;
        logic [3:0] sel;
        logic       valid;
        logic       turbo;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic [5:0] ma, input logic ce3, input int src,
                                input logic [3:0] s, input logic v, input logic t,
                                input logic e, input logic [7:0] c);
        vec_t r;
        r.ma = ma; r.ce3 = ce3; r.src = src; r.sel = s;
        r.valid = v; r.turbo = t; r.err = e; r.cnt = c;
        vt.push_back(r);
    endfunction

    task automatic set_channels(input logic ce3);
        for (int c = 0; c < NCH; c++) begin
            logic [7:0] cb;
            cb = 8'(c);
            ch_do[c*8 +: 8]         = 8'h10 + cb;
            ch_irq_n[c]             = cb[0];
            ch_rom_addr[c*24 +: 24] = (c == 0) ? 24'h123456 : 24'hA00000 + 24'(c);
            ch_rom_d[c*8 +: 8]      = 8'h20 + cb;
            ch_rom_ce_n[c]          = (c == 3) ? ce3 : 1'b1;
            ch_rom_oe_n[c]          = 1'b0;
            ch_rom_we_n[c]          = 1'b1;
            ch_rom_word[c]          = cb[1];
            ch_bsram_addr[c*20 +: 20] = 20'h50000 + 20'(c);
            ch_bsram_d[c*8 +: 8]    = 8'h30 + cb;
            ch_bsram_ce_n[c]        = 1'b1;
            ch_bsram_oe_n[c]        = 1'b0;
            ch_bsram_we_n[c]        = 1'b1;
        end
    endtask

    function automatic logic [83:0] exp_bundle(input int src, input logic ce3);
        logic [7:0]  cb;
        logic [23:0] a;
        if (src < 0) begin
            return {8'hFF, 1'b1, 24'h0, 16'h0, 3'b111, 1'b0, 20'h0, 8'h00, 3'b111};
        end
        cb = 8'(src);
        a  = (src == 0) ? 24'h123456 : 24'hA00000 + 24'(src);
        return {8'h10 + cb, cb[0], a, 8'h00, 8'h20 + cb, (src == 3) ? ce3 : 1'b1, 1'b0, 1'b1,
                cb[1], 20'h50000 + 20'(src), 8'h30 + cb, 3'b101};
    endfunction

    function automatic logic [83:0] act_bundle();
        return {di, irq_n, rom_addr, rom_d, rom_ce_n, rom_oe_n, rom_we_n, rom_word,
                bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n};
    endfunction

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        map_active = '0;
        set_channels(1'b1);
        repeat (3) tick();
        chk("rst_bundle", act_bundle(), exp_bundle(-1, 1'b1));
        chk("rst_sel", 84'(sel), 84'd0);
        chk("rst_valid", 84'(sel_valid), 84'd0);
        chk("rst_turbo", 84'(turbo_allow), 84'd1);
        chk("rst_err", 84'(map_err), 84'd0);
        chk("rst_cnt", 84'(err_cnt), 84'd0);

        //   ma         ce3   src sel  v     t     e     cnt
        add(6'h00, 1'b1, -1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(6'h00, 1'b1, -1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(6'h00, 1'b1, -1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(6'h00, 1'b1, -1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        add(6'h00, 1'b1,  0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        add(6'h04, 1'b0,  0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        add(6'h04, 1'b0, -1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(6'h04, 1'b0, -1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(6'h04, 1'b0, -1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(6'h04, 1'b0, -1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        add(6'h04, 1'b0, -1, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0);
        add(6'h04, 1'b0,  3, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0);
        add(6'h08, 1'b0,  3, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        add(6'h08, 1'b0,  3, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        add(6'h08, 1'b0,  3, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        add(6'h08, 1'b1, -1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        add(6'h08, 1'b1, -1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        add(6'h08, 1'b1, -1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        add(6'h08, 1'b1, -1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        add(6'h08, 1'b1, -1, 4'd4, 1'b1, 1'b0, 1'b0, 8'd0);
        add(6'h08, 1'b1,  4, 4'd4, 1'b1, 1'b0, 1'b0, 8'd0);
        add(6'h04, 1'b1,  4, 4'd4, 1'b1, 1'b1, 1'b0, 8'd0);
        add(6'h04, 1'b1, -1, 4'd4, 1'b0, 1'b1, 1'b0, 8'd0);
        add(6'h03, 1'b1, -1, 4'd4, 1'b0, 1'b0, 1'b1, 8'd1);
        add(6'h03, 1'b1, -1, 4'd4, 1'b0, 1'b0, 1'b1, 8'd1);
        add(6'h03, 1'b1, -1, 4'd4, 1'b0, 1'b0, 1'b1, 8'd1);
        add(6'h03, 1'b1, -1, 4'd4, 1'b0, 1'b0, 1'b1, 8'd1);
        add(6'h03, 1'b1, -1, 4'd0, 1'b1, 1'b0, 1'b1, 8'd1);
        add(6'h01, 1'b1,  0, 4'd0, 1'b1, 1'b1, 1'b1, 8'd1);
        add(6'h03, 1'b1, -1, 4'd0, 1'b0, 1'b0, 1'b1, 8'd2);
        add(6'h03, 1'b1, -1, 4'd0, 1'b0, 1'b0, 1'b1, 8'd2);
        add(6'h03, 1'b1, -1, 4'd0, 1'b0, 1'b0, 1'b1, 8'd2);
        add(6'h03, 1'b1, -1, 4'd0, 1'b0, 1'b0, 1'b1, 8'd2);
        add(6'h03, 1'b1, -1, 4'd0, 1'b1, 1'b0, 1'b1, 8'd2);

        rst = 1'b0;
        foreach (vt[i]) begin
            map_active = vt[i].ma;
            set_channels(vt[i].ce3);
            tick();
            chk($sformatf("v%0d_bundle", i), act_bundle(), exp_bundle(vt[i].src, vt[i].ce3));
            chk($sformatf("v%0d_sel", i), 84'(sel), 84'(vt[i].sel));
            chk($sformatf("v%0d_valid", i), 84'(sel_valid), 84'(vt[i].valid));
            chk($sformatf("v%0d_turbo", i), 84'(turbo_allow), 84'(vt[i].turbo));
            chk($sformatf("v%0d_err", i), 84'(map_err), 84'(vt[i].err));
            chk($sformatf("v%0d_errcnt", i), 84'(err_cnt), ERRCNT_ON ? 84'(vt[i].cnt) : 84'd0);
        end

        // Reach a held DRAIN on channel 3, then reset out of it.
        map_active = 6'h04;
        set_channels(1'b0);
        repeat (7) tick();
        chk("pre_drain_sel", 84'(sel), 84'd3);
        chk("pre_drain_bundle", act_bundle(), exp_bundle(3, 1'b0));
        map_active = 6'h08;
        repeat (2) tick();
        chk("drain_valid", 84'(sel_valid), 84'd1);
        chk("drain_bundle", act_bundle(), exp_bundle(3, 1'b0));
        rst = 1'b1;
        tick();
        chk("rst_drain_bundle", act_bundle(), exp_bundle(-1, 1'b0));
        chk("rst_drain_sel", 84'(sel), 84'd0);
        chk("rst_drain_valid", 84'(sel_valid), 84'd0);
        chk("rst_drain_err", 84'(map_err), 84'd0);
        chk("rst_drain_errcnt", 84'(err_cnt), 84'd0);
        chk("rst_drain_turbo", 84'(turbo_allow), 84'd1);

        // Flags toggling every 2 cycles never reach a full settle window.
        rst = 1'b0;
        set_channels(1'b1);
        for (int i = 0; i < 16; i++) begin
            map_active = ((i / 2) % 2 == 1) ? 6'h02 : 6'h01;
            tick();
            chk($sformatf("toggle%0d_valid", i), 84'(sel_valid), 84'd0);
            chk($sformatf("toggle%0d_bundle", i), act_bundle(), exp_bundle(-1, 1'b1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
